// File: rtl/serializador_pkg.sv
// Shared constants for the serializador transmitter and the registro receiver it feeds.
package serializador_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } estado_t;

   localparam logic DIR_IZQ = 1'b0;
   localparam logic DIR_DER = 1'b1;

   // registro modo field: hold, serial-left, serial-right, parallel load
   localparam logic [1:0] MODO_RETENER = 2'b00;
   localparam logic [1:0] MODO_IZQ     = 2'b01;
   localparam logic [1:0] MODO_DER     = 2'b10;
   localparam logic [1:0] MODO_CARGA   = 2'b11;

endpackage

// File: rtl/serializador_contador_bajada.sv
// Loadable down-counter with enable and zero flag; stops at zero.
module contador_bajada #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         enb,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         zero
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (enb && (q != '0)) begin
         q <= q - 1'b1;
      end
   end

   assign zero = (q == '0);

endmodule

// File: rtl/serializador.sv
// Parallel-to-serial transmitter feeding registro s_in/enb; one bit per enabled clock.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | ready=1, waiting for valid; accept latches d and dir
//   ST_SHIFT | emitting bits on enabled edges; leaves after last bit
module serializador
   import serializador_pkg::*;
#(
   parameter int N = 4,
   localparam int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enb,
   input  logic          dir,
   input  logic          valid,
   input  logic [N-1:0]  d,
   output logic          ready,
   output logic          s_out,
   output logic          s_vld,
   output logic [CW-1:0] cuenta,
   output logic          fin
);

   localparam logic [CW-1:0] CNT_N = CW'(N);

   estado_t        state, state_nx;
   logic [N-1:0]   sr, sr_nx;
   logic           dir_q, dir_nx;
   logic           ready_nx, s_out_nx, s_vld_nx, fin_nx;
   logic           cnt_load, cnt_dec, cnt_zero;

   contador_bajada #(.W(CW)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (cnt_load),
      .enb   (cnt_dec),
      .d     (CNT_N),
      .q     (cuenta),
      .zero  (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         sr    <= '0;
         dir_q <= DIR_IZQ;
         ready <= 1'b1;
         s_out <= 1'b0;
         s_vld <= 1'b0;
         fin   <= 1'b0;
      end else begin
         state <= state_nx;
         sr    <= sr_nx;
         dir_q <= dir_nx;
         ready <= ready_nx;
         s_out <= s_out_nx;
         s_vld <= s_vld_nx;
         fin   <= fin_nx;
      end
   end

   always_comb begin
      state_nx = state;
      sr_nx    = sr;
      dir_nx   = dir_q;
      ready_nx = ready;
      s_out_nx = s_out;
      s_vld_nx = 1'b0;
      fin_nx   = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state)
         ST_IDLE: begin
            ready_nx = 1'b1;
            s_out_nx = 1'b0;
            if (valid) begin
               sr_nx    = d;
               dir_nx   = dir;
               cnt_load = 1'b1;
               ready_nx = 1'b0;
               state_nx = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            ready_nx = 1'b0;
            // cuenta reaching zero means the last bit is already on the line
            if (cnt_zero) begin
               state_nx = ST_IDLE;
               fin_nx   = 1'b1;
               ready_nx = 1'b1;
               s_out_nx = 1'b0;
            end else if (enb) begin
               s_vld_nx = 1'b1;
               cnt_dec  = 1'b1;
               if (dir_q == DIR_IZQ) begin
                  s_out_nx = sr[N-1];
                  sr_nx    = {sr[N-2:0], 1'b0};
               end else begin
                  s_out_nx = sr[0];
                  sr_nx    = {1'b0, sr[N-1:1]};
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_serializador.sv
// Self-checking bench for serializador: vector table, hand sequences, random frames.
module tb_serializador;
   import serializador_pkg::*;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enb = 1'b0;
   logic       dir = 1'b0;
   logic       valid = 1'b0;
   logic [3:0] d = '0;
   logic       ready, s_out, s_vld, fin;
   logic [2:0] cuenta;

   int checks = 0;
   int failures = 0;

   serializador #(.N(N)) dut (
      .clk    (clk),
      .reset  (reset),
      .enb    (enb),
      .dir    (dir),
      .valid  (valid),
      .d      (d),
      .ready  (ready),
      .s_out  (s_out),
      .s_vld  (s_vld),
      .cuenta (cuenta),
      .fin    (fin)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  w;
      logic        dr;
      logic [15:0] pat;
      logic [3:0]  seq;
      bit          noise;
   } vec_t;

   vec_t tbl[5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Emission order expected on the line, first bit in seq[3].
   function automatic logic [3:0] ref_seq(input logic [3:0] w, input logic dr);
      logic [3:0] r;
      for (int i = 0; i < N; i++)
         r[N-1-i] = (dr == DIR_DER) ? w[i] : w[N-1-i];
      return r;
   endfunction

   // Accepts one word, then walks the frame checking every cycle; returns in the fin cycle.
   task automatic frame(input logic [3:0] w, input logic dr, input logic [15:0] pat,
                        input logic [3:0] seq, input bit noise, input string tag);
      logic [3:0] rx;
      logic       last, en, bitx;
      int         idx;
      bit         done;
      chk({tag, "_ready_pre"}, ready, 1);
      valid = 1'b1;
      d     = w;
      dir   = dr;
      enb   = 1'($urandom);
      tick();
      chk({tag, "_acc_ready"}, ready, 0);
      chk({tag, "_acc_svld"}, s_vld, 0);
      chk({tag, "_acc_sout"}, s_out, 0);
      chk({tag, "_acc_cuenta"}, cuenta, N);
      chk({tag, "_acc_fin"}, fin, 0);
      if (noise) begin
         d   = 4'b0001;
         dir = ~dr;
      end else begin
         valid = 1'b0;
      end
      rx = '0; idx = 0; last = 1'b0; done = 0;
      for (int e = 0; e < 64 && !done; e++) begin
         en  = (e < 16) ? pat[e] : 1'b1;
         enb = en;
         tick();
         if (idx == N) begin
            chk({tag, "_fin"}, fin, 1);
            chk({tag, "_fin_ready"}, ready, 1);
            chk({tag, "_fin_svld"}, s_vld, 0);
            chk({tag, "_fin_sout"}, s_out, 0);
            chk({tag, "_fin_cuenta"}, cuenta, 0);
            chk({tag, "_rx_q"}, rx, w);
            done = 1;
         end else if (en) begin
            bitx = seq[N-1-idx];
            idx++;
            chk({tag, "_svld"}, s_vld, 1);
            chk({tag, "_sout"}, s_out, bitx);
            chk({tag, "_cuenta"}, cuenta, N - idx);
            chk({tag, "_nofin"}, fin, 0);
            last = bitx;
            if (dr == DIR_IZQ) rx = {rx[2:0], s_out};
            else               rx = {s_out, rx[3:1]};
         end else begin
            chk({tag, "_pause_svld"}, s_vld, 0);
            chk({tag, "_pause_sout"}, s_out, last);
            chk({tag, "_pause_cuenta"}, cuenta, N - idx);
            chk({tag, "_pause_ready"}, ready, 0);
         end
         if (noise) dir = ~dir;
      end
      if (!done) chk({tag, "_timeout"}, 0, 1);
   endtask

   initial begin
      tbl[0] = '{4'b1011, DIR_IZQ, 16'hffff, 4'b1011, 1'b0};
      tbl[1] = '{4'b1011, DIR_DER, 16'hffff, 4'b1101, 1'b0};
      tbl[2] = '{4'b0110, DIR_IZQ, 16'hfff3, 4'b0110, 1'b0};
      tbl[3] = '{4'b1001, DIR_IZQ, 16'hffff, 4'b1001, 1'b1};
      tbl[4] = '{4'b1100, DIR_IZQ, 16'hffff, 4'b1100, 1'b0};

      // reset with valid pending
      reset = 1'b1; valid = 1'b1; d = 4'b1111; enb = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_ready", ready, 1);
         chk("rst_svld", s_vld, 0);
         chk("rst_sout", s_out, 0);
         chk("rst_cuenta", cuenta, 0);
         chk("rst_fin", fin, 0);
      end
      reset = 1'b0; valid = 1'b0;
      tick();
      chk("post_rst_ready", ready, 1);
      chk("post_rst_cuenta", cuenta, 0);
      chk("post_rst_svld", s_vld, 0);

      // vector table, frames chained back to back through the fin cycle
      for (int i = 0; i < 5; i++)
         frame(tbl[i].w, tbl[i].dr, tbl[i].pat, tbl[i].seq, tbl[i].noise, $sformatf("vec%0d", i));
      valid = 1'b0;
      tick();
      chk("after_vec_fin", fin, 0);
      chk("after_vec_ready", ready, 1);

      // abort by reset at the third bit
      valid = 1'b1; d = 4'b1010; dir = DIR_IZQ; enb = 1'b1;
      tick();
      valid = 1'b0;
      tick();
      chk("abort_b1", s_out, 1);
      tick();
      chk("abort_b2_vld", s_vld, 1);
      chk("abort_b2", s_out, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_ready", ready, 1);
      chk("abort_svld", s_vld, 0);
      chk("abort_sout", s_out, 0);
      chk("abort_cuenta", cuenta, 0);
      chk("abort_fin", fin, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("abort_nofin", fin, 0);
         chk("abort_idle_svld", s_vld, 0);
      end
      frame(4'b1010, DIR_IZQ, 16'hffff, 4'b1010, 1'b0, "post_abort");

      // random frames against the reference order
      for (int i = 0; i < 40; i++) begin
         logic [3:0]  w;
         logic        dr;
         logic [15:0] pat;
         bit          noise;
         int          gap;
         w     = 4'($urandom);
         dr    = 1'($urandom);
         pat   = 16'($urandom);
         noise = 1'($urandom);
         gap   = $urandom_range(0, 2);
         valid = 1'b0;
         for (int g = 0; g < gap; g++) begin
            enb = 1'($urandom);
            tick();
            chk("rnd_gap_ready", ready, 1);
            chk("rnd_gap_svld", s_vld, 0);
         end
         frame(w, dr, pat, ref_seq(w, dr), noise, $sformatf("rnd%0d", i));
      end
      valid = 1'b0;
      tick();
      chk("final_fin", fin, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serializador.md
Name: serializador

Overview:
Parallel-to-serial transmitter that drives the serial input of the team's universal shift register `registro`. It accepts an N-bit word over a valid/ready handshake and emits the word one bit per enabled clock. It also emits a per-bit strobe that the receiving register uses as its shift enable. When `registro` runs in serial-load mode with a matching direction, its q ends equal to the transmitted word.

Parameters:
- N, 4, word width in bits (N >= 2).
- CW, $clog2(N+1), width of the bit counter (derived localparam, not overridable).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enb  input  1  shift enable; 0 pauses transmission mid-frame.
- dir  input  1  order; 0 = MSB first (receiver shifts left), 1 = LSB first (receiver shifts right); sampled at accept.
- valid  input  1  d holds a word to send.
- d  input  N  parallel word; sampled at accept.
- ready  output  1  transmitter idle, can accept.
- s_out  output  1  serial data, drives registro s_in.
- s_vld  output  1  bit on s_out is valid this cycle, drives registro enb.
- cuenta  output  CW  bits remaining in the current frame.
- fin  output  1  one-cycle pulse, frame completed.

Behaviour:
- Clock is `clk`; reset is synchronous, active-high, named `reset`. All outputs are registered.
- Reset values: ready=1, s_out=0, s_vld=0, cuenta=0, fin=0, state=IDLE, shift register=0, latched dir=0.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - ready=1, s_vld=0, s_out=0.
  - Accept occurs at the edge where valid=1; enb is irrelevant to accept.
  - On accept: latch d and dir, set cuenta=N, go to SHIFT, ready=0.
- SHIFT, on an edge with enb=1:
  - Present the next bit on s_out and set s_vld=1.
  - dir=0 sends d[N-1] down to d[0]; dir=1 sends d[0] up to d[N-1].
  - cuenta decrements by 1.
- SHIFT, on an edge with enb=0:
  - s_vld=0; s_out holds its last value; cuenta and shift register hold.
  - If enb=0 before the first bit, s_out stays 0.
- Latency: with enb held at 1, the first bit is valid in the cycle after the accept edge + 1. Bits occupy N consecutive s_vld=1 cycles.
- End of frame:
  - On the edge following the last bit (cuenta=0), go to IDLE.
  - In that same cycle: fin=1 (exactly one cycle), ready=1, s_vld=0, s_out=0.
  - If valid=1 at the next edge, the following word is accepted. There is no back-to-back accept inside SHIFT.
- During SHIFT:
  - valid and d are ignored; no accept occurs.
  - dir changes have no effect until the next accept.
- Reset during SHIFT: the frame is aborted at that edge, all outputs take reset values, and no fin is pulsed.
- Reset and valid asserted in the same cycle: reset wins; no accept.

Decomposition:
- Shared package/include holds:
  - state encoding localparams: ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - direction constants: DIR_IZQ=0, DIR_DER=1;
  - the `registro` modo encoding constants, so benches drive the transmitter/registro pair consistently.
- One natural sub-module: `contador_bajada`, a CW-bit loadable down-counter with enable and a zero flag, used for cuenta.
- The shift register and FSM stay in serializador.

Test Plan:
1. Reset: assert reset 2 cycles with valid=1, d=4'b1111 -> ready=1, s_vld=0, s_out=0, cuenta=0, fin=0; no frame starts.
2. Left frame: dir=0, d=4'b1011, valid pulsed 1 cycle, enb=1 -> s_out = 1,0,1,1 on 4 consecutive s_vld=1 cycles; cuenta 3,2,1,0; fin=1 one cycle after. A chained registro in serial-left mode gets q=4'b1011.
3. Right frame: dir=1, d=4'b1011 -> s_out = 1,1,0,1; the chained registro shifting right gets q=4'b1011.
4. Pause: d=4'b0110, dir=0, enb=0 for 2 cycles after the 2nd bit -> s_vld=0 and s_out=1 held, cuenta=2 held; then bits 1,0 resume; fin after the 4th valid bit.
5. Handshake:
   - valid held high with d changing to 4'b0001 and dir toggled during SHIFT -> ready=0, frame unchanged.
   - In the fin cycle, with d=4'b1100 -> accepted; next frame emits 1,1,0,0.
6. Abort: reset for 1 cycle at the 3rd bit of d=4'b1010 -> next cycle all outputs at reset values; fin never asserts; a new valid then sends a full 4-bit frame.
